// File: rtl/cwc_capture_ctrl.sv
// rtl/cwc_capture_ctrl.sv - debug watcher trigger/capture sequencer with pre-trigger window and streamed readout
module cwc_capture_ctrl #(
  parameter int DATA_W = 17,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] probe_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              rd_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_pos
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE, S_READ} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W:0]   R_FULL    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   R_ONE     = (ADDR_W + 1)'(1);

  state_t state, nxt;

  logic [DATA_W-1:0] sample_q, value_q, mask_q, out_data_q;
  logic [ADDR_W-1:0] pre_len_q, waddr_q, cnt_q, rptr_q, trig_pos_q;
  logic [ADDR_W:0]   rd_left_q;
  logic              in_flight_q, pend_last_q, trig_q, out_valid_q, out_last_q;

  logic              match, writing, arm_go, rd_go, rd_issue, out_fire;
  logic [ADDR_W-1:0] post_len;

  assign match    = ((sample_q ^ value_q) & mask_q) == '0;
  assign post_len = LAST_ADDR - pre_len_q;
  assign writing  = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign arm_go   = arm && ((state == S_IDLE) || (state == S_DONE));
  assign rd_go    = (state == S_DONE) && rd_start && !arm;
  assign out_fire = out_valid_q && out_ready;
  // Only one read in flight, and only when the output register is free or draining.
  assign rd_issue = (state == S_READ) && !in_flight_q && (rd_left_q != '0) &&
                    (!out_valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (arm) nxt = (pretrig_len == '0) ? S_WAIT : S_PRE;
        S_PRE:   if (cnt_q == A_ONE) nxt = S_WAIT;
        S_WAIT:  if (match) nxt = (post_len == '0) ? S_DONE : S_POST;
        S_POST:  if (cnt_q == A_ONE) nxt = S_DONE;
        S_DONE: begin
          if (arm)           nxt = (pretrig_len == '0) ? S_WAIT : S_PRE;
          else if (rd_start) nxt = S_READ;
        end
        S_READ:  if (out_fire && out_last_q) nxt = S_DONE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_we    = writing;
    ram_waddr = waddr_q;
    ram_wdata = writing ? sample_q : '0;
    ram_re    = rd_issue;
    ram_raddr = rptr_q;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_last  = out_last_q;
    busy      = writing || (state == S_READ);
    triggered = trig_q;
    done      = (state == S_DONE);
    trig_pos  = trig_pos_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q    <= '0;
      value_q     <= '0;
      mask_q      <= '0;
      out_data_q  <= '0;
      pre_len_q   <= '0;
      waddr_q     <= '0;
      cnt_q       <= '0;
      rptr_q      <= '0;
      trig_pos_q  <= '0;
      rd_left_q   <= '0;
      in_flight_q <= 1'b0;
      pend_last_q <= 1'b0;
      trig_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      sample_q <= probe_data;
      if (abort) begin
        trig_q      <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        in_flight_q <= 1'b0;
      end else begin
        if (arm_go) begin
          value_q   <= trig_value;
          mask_q    <= trig_mask;
          pre_len_q <= pretrig_len;
          waddr_q   <= '0;
          cnt_q     <= pretrig_len;
          trig_q    <= 1'b0;
        end else if (writing) begin
          waddr_q <= waddr_q + A_ONE;
          if (state == S_WAIT) begin
            if (match) begin
              trig_pos_q <= waddr_q;
              trig_q     <= 1'b1;
              cnt_q      <= post_len;
            end
          end else begin
            cnt_q <= cnt_q - A_ONE;
          end
        end
        if (rd_go) begin
          rptr_q    <= trig_pos_q - pre_len_q;
          rd_left_q <= R_FULL;
        end
        if (rd_issue) begin
          rptr_q      <= rptr_q + A_ONE;
          rd_left_q   <= rd_left_q - R_ONE;
          pend_last_q <= (rd_left_q == R_ONE);
          in_flight_q <= 1'b1;
        end
        if (out_fire) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
        if (in_flight_q) begin
          out_data_q  <= ram_rdata;
          out_valid_q <= 1'b1;
          out_last_q  <= pend_last_q;
          in_flight_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cwc_capture_ctrl.sv
// tb/tb_cwc_capture_ctrl.sv - scoreboard bench for cwc_capture_ctrl with RAM and capture-window model
module tb_cwc_capture_ctrl;
  localparam int DW = 17;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, arm, abort, rd_start, out_ready;
  logic [AW-1:0] pretrig_len;
  logic [DW-1:0] trig_value, trig_mask, probe_data, ram_rdata;
  logic ram_we, ram_re, out_valid, out_last, busy, triggered, done;
  logic [AW-1:0] ram_waddr, ram_raddr, trig_pos;
  logic [DW-1:0] ram_wdata, out_data;

  cwc_capture_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .pretrig_len(pretrig_len),
    .trig_value(trig_value), .trig_mask(trig_mask), .probe_data(probe_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .rd_start(rd_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy),
    .triggered(triggered), .done(done), .trig_pos(trig_pos)
  );

  typedef struct {logic [DW-1:0] data; logic last;} beat_t;

  beat_t exp_q[$];
  beat_t win[DEPTH];
  logic [DW-1:0] plog[$];
  logic [DW-1:0] mem[DEPTH];
  int n_cmp = 0, n_err = 0;
  int wcnt = 0, beats = 0;
  int pmode = 0, rdy_mode = 0, rdy_idx = 0;
  logic [DW-1:0] pcnt = '0;
  bit mon_skip = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture RAM: control sampled mid-cycle, applied just after the edge (1-cycle read latency).
  initial begin
    logic we_s, re_s;
    logic [AW-1:0] wa_s, ra_s;
    logic [DW-1:0] wd_s;
    ram_rdata = '0;
    forever begin
      @(negedge clk);
      we_s = ram_we; re_s = ram_re; wa_s = ram_waddr; ra_s = ram_raddr; wd_s = ram_wdata;
      if (ram_we) wcnt++;
      @(posedge clk);
      #1;
      if (we_s) mem[wa_s] = wd_s;
      if (re_s) ram_rdata = mem[ra_s];
    end
  end

  // Monitor: pops expected beats on each handshake and checks stall stability.
  initial begin
    bit stall;
    logic [DW-1:0] held;
    beat_t e;
    stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (stall && !mon_skip) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_beat: got %0h expected no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", out_data, e.data);
          chk("rd_last", out_last, e.last);
        end
      end
      stall = out_valid && !out_ready;
      held = out_data;
    end
  end

  task automatic next_probe();
    if (pmode == 0) begin
      probe_data = pcnt;
      pcnt++;
    end else begin
      probe_data = DW'($urandom);
    end
    plog.push_back(probe_data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    next_probe();
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    rdy_idx++;
  endtask

  task automatic start_capture(input int pre, input logic [DW-1:0] val, input logic [DW-1:0] msk);
    pretrig_len = AW'(pre);
    trig_value = val;
    trig_mask = msk;
    plog.delete();
    pcnt = '0;
    wcnt = 0;
    arm = 1'b1;
    next_probe();
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 4000) begin tick(); n++; end
    chk("done_reached", done, 1);
  endtask

  task automatic wait_trig();
    int n = 0;
    while (!triggered && n < 4000) begin tick(); n++; end
    chk("trig_reached", triggered, 1);
  endtask

  // Reference: the trigger is the first match at or after the pre-window; the window is the
  // DEPTH samples starting pre samples before it.
  task automatic model_check(input int pre, input logic [DW-1:0] val, input logic [DW-1:0] msk);
    int k = -1;
    for (int i = pre; i < plog.size(); i++)
      if (((plog[i] ^ val) & msk) == '0) begin k = i; break; end
    if (k < 0 || k + DEPTH - pre > plog.size()) begin
      n_cmp++;
      n_err++;
      $display("FAIL model_trigger: got done=%0d expected no trigger in %0d samples", done, plog.size());
      for (int j = 0; j < DEPTH; j++) begin win[j].data = '0; win[j].last = 1'b0; end
    end else begin
      chk("trig_pos", trig_pos, 64'(k % DEPTH));
      chk("triggered", triggered, 1);
      chk("write_count", wcnt, 64'(k + DEPTH - pre));
      for (int j = 0; j < DEPTH; j++) begin
        win[j].data = plog[k - pre + j];
        win[j].last = (j == DEPTH - 1);
      end
    end
  endtask

  task automatic start_read();
    beats = 0;
    for (int j = 0; j < DEPTH; j++) exp_q.push_back(win[j]);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic read_out();
    int n = 0;
    start_read();
    while ((exp_q.size() != 0 || !done) && n < 400) begin tick(); n++; end
    chk("rd_drained", exp_q.size(), 0);
    chk("rd_beats", beats, DEPTH);
  endtask

  function automatic logic [52:0] all_outs();
    return {ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr, out_valid, out_data,
            out_last, busy, triggered, done, trig_pos};
  endfunction

  initial begin
    logic [DW-1:0] m, v;
    int pre;
    rst = 1'b1; arm = 1'b0; abort = 1'b0; rd_start = 1'b0; out_ready = 1'b1;
    pretrig_len = '0; trig_value = '0; trig_mask = '0; probe_data = '0;
    repeat (3) tick();
    chk("reset_outs", all_outs(), 0);
    rst = 1'b0;
    tick();

    // Counter probe, trigger at 0x105 after wrap.
    start_capture(4, 17'h00105, 17'h1FFFF);
    wait_done();
    chk("t1_trig_pos", trig_pos, 5);
    model_check(4, 17'h00105, 17'h1FFFF);
    read_out();

    // All-zero mask, no pre-window.
    start_capture(0, 17'h0, 17'h0);
    wait_done();
    chk("t2_trig_pos", trig_pos, 0);
    model_check(0, 17'h0, 17'h0);
    read_out();

    // Full pre-window: POST skipped; ready pattern 1,0,0,1 then random re-read.
    start_capture(15, 17'h00020, 17'h1FFFF);
    wait_done();
    model_check(15, 17'h00020, 17'h1FFFF);
    rdy_mode = 1; rdy_idx = 0;
    read_out();
    rdy_mode = 2;
    read_out();
    rdy_mode = 0;

    // arm during WAIT_TRIG and rd_start during POST are ignored.
    start_capture(4, 17'h00105, 17'h1FFFF);
    repeat (20) tick();
    trig_value = 17'h7; trig_mask = '0; pretrig_len = '0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_ign_busy", busy, 1);
    chk("arm_ign_trig", triggered, 0);
    wait_trig();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("rds_ign_we", ram_we, 1);
    chk("rds_ign_done", done, 0);
    wait_done();
    model_check(4, 17'h00105, 17'h1FFFF);

    // rst during READ.
    start_read();
    repeat (5) tick();
    mon_skip = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_read_outs", all_outs(), 0);
    exp_q.delete();
    tick();
    mon_skip = 1'b0;

    // abort during POST.
    start_capture(4, 17'h00105, 17'h1FFFF);
    wait_trig();
    chk("post_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_post_busy", busy, 0);
    chk("abort_post_trig", triggered, 0);
    chk("abort_post_we", ram_we, 0);

    // abort during READ with a stalled sample.
    start_capture(0, 17'h0, 17'h0);
    wait_done();
    model_check(0, 17'h0, 17'h0);
    rdy_mode = 3;
    start_read();
    begin
      int n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
    end
    chk("read_valid", out_valid, 1);
    mon_skip = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rd_valid", out_valid, 0);
    chk("abort_rd_busy", busy, 0);
    chk("abort_rd_trig", triggered, 0);
    chk("abort_rd_re", ram_re, 0);
    chk("abort_rd_done", done, 0);
    exp_q.delete();
    rdy_mode = 0;
    tick();
    mon_skip = 1'b0;

    // Randomized captures with random probes, masks and ready behaviour.
    pmode = 1;
    for (int it = 0; it < 8; it++) begin
      pre = $urandom_range(0, DEPTH - 1);
      m = '0;
      if (it != 3) repeat (3) m[$urandom_range(0, DW - 1)] = 1'b1;
      v = DW'($urandom);
      rdy_mode = $urandom_range(0, 2);
      start_capture(pre, v, m);
      wait_done();
      model_check(pre, v, m);
      read_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
